brg_systolic_link_fifo: RTL and testbench

Elastic buffer on one link of the systolic network between adjacent accelerator tiles. It takes the out_row/out_col valid/ready stream of one tile and drives the in_row/in_col stream of its east or south neighbour. It decouples the producer's ready from the consumer's ready with registered, cycle-level timing, so that neither tile sees a combinational path through the other. It also keeps occupancy and transfer counters for debug.

---
 rtl/brg_systolic_pkg.sv | 25 ++
 rtl/brg_systolic_circ_ptr.sv | 25 ++
 rtl/brg_systolic_link_fifo.sv | 96 +++++++++
 tb/tb_brg_systolic_link_fifo.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/brg_systolic_pkg.sv
// Shared definitions for the systolic tile network: message widths and layout.
package brg_systolic_pkg;

    localparam int BRG_SYS_MSG_W  = 38;
    localparam int BRG_SYS_DATA_W = 32;
    localparam int BRG_SYS_TAG_W  = 6;

    // One network message: an opaque tag above a 32-bit data word.
    typedef struct packed {
        logic [BRG_SYS_TAG_W-1:0]  tag;
        logic [BRG_SYS_DATA_W-1:0] data;
    } brg_sys_msg_s;

    // Builds a message from its tag and data fields.
    function automatic brg_sys_msg_s brg_sys_make_msg(
        input logic [BRG_SYS_TAG_W-1:0]  tag,
        input logic [BRG_SYS_DATA_W-1:0] data
    );
        brg_sys_msg_s m;
        m.tag  = tag;
        m.data = data;
        return m;
    endfunction

endpackage

// File: rtl/brg_systolic_circ_ptr.sv
// Wrapping pointer over els_p slots; els_p need not be a power of two.
module brg_systolic_circ_ptr #(
    parameter int els_p        = 2,
    parameter int ptr_width_lp = $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    incr_i,
    output logic [ptr_width_lp-1:0] ptr_o
);

    logic [ptr_width_lp-1:0] r_ptr;

    // Advance on each event, wrapping from the last slot back to slot 0.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_ptr <= '0;
        end else if (incr_i) begin
            r_ptr <= (r_ptr == ptr_width_lp'(els_p - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

    assign ptr_o = r_ptr;

endmodule

// File: rtl/brg_systolic_link_fifo.sv
// Elastic buffer between two systolic tiles. Both handshake outputs come only
// from registered occupancy, so neither tile sees a combinational path through
// the other. Also keeps a running dequeue count for debug.
module brg_systolic_link_fifo
    import brg_systolic_pkg::*;
#(
    parameter int els_p          = 2,
    parameter int msg_width_p    = BRG_SYS_MSG_W,
    parameter int count_width_lp = $clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic [msg_width_p-1:0]    in_msg,
    input  logic                      in_val,
    output logic                      in_rdy,
    output logic [msg_width_p-1:0]    out_msg,
    output logic                      out_val,
    input  logic                      out_rdy,
    output logic [count_width_lp-1:0] count_o,
    output logic [31:0]               xfer_count_o
);

    localparam int PtrW = $clog2(els_p);

    logic                      w_enq;
    logic                      w_deq;
    logic [PtrW-1:0]           w_wptr;
    logic [PtrW-1:0]           w_rptr;
    logic [count_width_lp-1:0] r_count;
    logic [31:0]               r_xfer_count;
    logic [msg_width_p-1:0]    r_mem [els_p];

    assign in_rdy  = (r_count != count_width_lp'(els_p));
    assign out_val = (r_count != '0);
    assign w_enq   = in_val && in_rdy;
    assign w_deq   = out_val && out_rdy;
    assign out_msg = out_val ? r_mem[w_rptr] : '0;
    assign count_o = r_count;
    assign xfer_count_o = r_xfer_count;

    brg_systolic_circ_ptr #(.els_p(els_p)) u_wptr (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .incr_i   (w_enq),
        .ptr_o    (w_wptr)
    );

    brg_systolic_circ_ptr #(.els_p(els_p)) u_rptr (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .incr_i   (w_deq),
        .ptr_o    (w_rptr)
    );

    // Message storage; contents survive reset because the count masks them.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[w_wptr] <= in_msg;
        end
    end

    // Occupancy: simultaneous enqueue and dequeue leave it unchanged.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_count <= '0;
        end else begin
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Debug count of dequeued messages, wrapping naturally at 2^32.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_xfer_count <= '0;
        end else if (w_deq) begin
            r_xfer_count <= r_xfer_count + 32'd1;
        end
    end

    a_in_stable: assert property (@(posedge clk_i) disable iff (!reset_ni)
        (in_val && !in_rdy) |=> (in_val && $stable(in_msg)))
        else $error("upstream changed in_val/in_msg before acceptance");

    a_no_enq_full: assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(w_enq && (r_count == count_width_lp'(els_p))))
        else $error("enqueue while full");

    a_no_deq_empty: assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(w_deq && (r_count == '0)))
        else $error("dequeue while empty");

endmodule

// File: tb/tb_brg_systolic_link_fifo.sv
// Bench for the link FIFO: directed scenarios on a depth-2 instance and
// randomized backpressure on depth-3 and depth-5 instances against a queue model.
module tb_brg_systolic_link_fifo;
    import brg_systolic_pkg::*;

    logic        clk = 1'b0;
    logic        resetN;
    logic [37:0] inMsg  [3];
    logic        inVal  [3];
    logic        inRdy  [3];
    logic [37:0] outMsg [3];
    logic        outVal [3];
    logic        outRdy [3];
    logic [31:0] xfer   [3];
    logic [1:0]  cnt0;
    logic [1:0]  cnt1;
    logic [2:0]  cnt2;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    brg_systolic_link_fifo #(.els_p(2)) dut0 (
        .clk_i(clk), .reset_ni(resetN), .in_msg(inMsg[0]), .in_val(inVal[0]), .in_rdy(inRdy[0]),
        .out_msg(outMsg[0]), .out_val(outVal[0]), .out_rdy(outRdy[0]), .count_o(cnt0), .xfer_count_o(xfer[0]));

    brg_systolic_link_fifo #(.els_p(3)) dut1 (
        .clk_i(clk), .reset_ni(resetN), .in_msg(inMsg[1]), .in_val(inVal[1]), .in_rdy(inRdy[1]),
        .out_msg(outMsg[1]), .out_val(outVal[1]), .out_rdy(outRdy[1]), .count_o(cnt1), .xfer_count_o(xfer[1]));

    brg_systolic_link_fifo #(.els_p(5)) dut2 (
        .clk_i(clk), .reset_ni(resetN), .in_msg(inMsg[2]), .in_val(inVal[2]), .in_rdy(inRdy[2]),
        .out_msg(outMsg[2]), .out_val(outVal[2]), .out_rdy(outRdy[2]), .count_o(cnt2), .xfer_count_o(xfer[2]));

    // Occupancy of instance idx as a plain integer.
    function automatic int cnt_of(input int idx);
        case (idx)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    // Holds reset for two cycles, releasing it away from any rising edge.
    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inVal[i] = 1'b0; outRdy[i] = 1'b0; inMsg[i] = '0;
        end
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetN = 1'b0;
        #1;
        nChecks++; if (inRdy[0] !== 1'b1) $display("[TB] FAIL reset_in_rdy got %b exp 1", inRdy[0]); else nPass++;
        nChecks++; if (outVal[0] !== 1'b0) $display("[TB] FAIL reset_out_val got %b exp 0", outVal[0]); else nPass++;
        nChecks++; if (outMsg[0] !== 38'h0) $display("[TB] FAIL reset_out_msg got %h exp 0", outMsg[0]); else nPass++;
        nChecks++; if (cnt_of(0) != 0) $display("[TB] FAIL reset_count got %0d exp 0", cnt_of(0)); else nPass++;
        nChecks++; if (xfer[0] !== 32'h0) $display("[TB] FAIL reset_xfer got %0d exp 0", xfer[0]); else nPass++;
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_single();
        logic [37:0] m;
        m = {6'h0A, 32'hDEADBEEF};
        @(negedge clk);
        inMsg[0] = m; inVal[0] = 1'b1; outRdy[0] = 1'b0;
        @(negedge clk);
        inVal[0] = 1'b0;
        nChecks++; if (outVal[0] !== 1'b1) $display("[TB] FAIL single_out_val got %b exp 1", outVal[0]); else nPass++;
        nChecks++; if (outMsg[0] !== m) $display("[TB] FAIL single_out_msg got %h exp %h", outMsg[0], m); else nPass++;
        nChecks++; if (cnt_of(0) != 1) $display("[TB] FAIL single_count got %0d exp 1", cnt_of(0)); else nPass++;
        outRdy[0] = 1'b1;
        @(negedge clk);
        outRdy[0] = 1'b0;
        nChecks++; if (outVal[0] !== 1'b0) $display("[TB] FAIL single_drained got %b exp 0", outVal[0]); else nPass++;
        nChecks++; if (xfer[0] !== 32'd1) $display("[TB] FAIL single_xfer got %0d exp 1", xfer[0]); else nPass++;
    endtask

    task automatic test_fill_stall();
        @(negedge clk);
        inMsg[0] = 38'h1; inVal[0] = 1'b1; outRdy[0] = 1'b0;
        @(negedge clk);
        nChecks++; if (inRdy[0] !== 1'b1) $display("[TB] FAIL fill_rdy_one got %b exp 1", inRdy[0]); else nPass++;
        inMsg[0] = 38'h2;
        @(negedge clk);
        nChecks++; if (inRdy[0] !== 1'b0) $display("[TB] FAIL fill_rdy_full got %b exp 0", inRdy[0]); else nPass++;
        nChecks++; if (cnt_of(0) != 2) $display("[TB] FAIL fill_count got %0d exp 2", cnt_of(0)); else nPass++;
        inMsg[0] = 38'h3;
        @(negedge clk);
        nChecks++; if (cnt_of(0) != 2) $display("[TB] FAIL stall_count got %0d exp 2", cnt_of(0)); else nPass++;
        nChecks++; if (outMsg[0] !== 38'h1) $display("[TB] FAIL stall_head got %h exp 1", outMsg[0]); else nPass++;
        outRdy[0] = 1'b1;
        @(negedge clk);
        nChecks++; if (cnt_of(0) != 1) $display("[TB] FAIL release_count got %0d exp 1", cnt_of(0)); else nPass++;
        nChecks++; if (inRdy[0] !== 1'b1) $display("[TB] FAIL release_rdy got %b exp 1", inRdy[0]); else nPass++;
        nChecks++; if (outMsg[0] !== 38'h2) $display("[TB] FAIL release_msg2 got %h exp 2", outMsg[0]); else nPass++;
        @(negedge clk);
        inVal[0] = 1'b0;
        nChecks++; if (outMsg[0] !== 38'h3) $display("[TB] FAIL release_msg3 got %h exp 3", outMsg[0]); else nPass++;
        nChecks++; if (cnt_of(0) != 1) $display("[TB] FAIL release_count3 got %0d exp 1", cnt_of(0)); else nPass++;
        @(negedge clk);
        outRdy[0] = 1'b0;
        nChecks++; if (outVal[0] !== 1'b0) $display("[TB] FAIL fill_empty got %b exp 0", outVal[0]); else nPass++;
        nChecks++; if (xfer[0] !== 32'd4) $display("[TB] FAIL fill_xfer got %0d exp 4", xfer[0]); else nPass++;
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                nChecks++; if (cnt_of(0) != 1) $display("[TB] FAIL stream_count[%0d] got %0d exp 1", i, cnt_of(0)); else nPass++;
                nChecks++; if (outMsg[0] !== 38'(i - 1)) $display("[TB] FAIL stream_msg[%0d] got %h exp %h", i, outMsg[0], 38'(i - 1)); else nPass++;
                nChecks++; if (inRdy[0] !== 1'b1) $display("[TB] FAIL stream_rdy[%0d] got %b exp 1", i, inRdy[0]); else nPass++;
                nChecks++; if (xfer[0] !== 32'(i - 1)) $display("[TB] FAIL stream_xfer[%0d] got %0d exp %0d", i, xfer[0], i - 1); else nPass++;
            end
            if (i < 100) begin
                inVal[0] = 1'b1; inMsg[0] = 38'(i); outRdy[0] = 1'b1;
            end else begin
                inVal[0] = 1'b0;
            end
        end
        @(negedge clk);
        outRdy[0] = 1'b0;
        nChecks++; if (outVal[0] !== 1'b0) $display("[TB] FAIL stream_drained got %b exp 0", outVal[0]); else nPass++;
    endtask

    // Random valid/ready traffic checked cycle by cycle against a queue model.
    task automatic test_random_backpressure(input int idx, input int els, input int nMsgs);
        logic [37:0] model [$];
        int  delivered = 0;
        int  sent = 0;
        int  cycles = 0;
        bit  pending = 0;
        bit  enq, deq;
        logic [37:0] expMsg;
        while (delivered < nMsgs && cycles < nMsgs * 8) begin
            @(negedge clk);
            cycles++;
            expMsg = (model.size() != 0) ? model[0] : 38'h0;
            nChecks++; if (cnt_of(idx) != model.size()) $display("[TB] FAIL rnd%0d_count got %0d exp %0d", idx, cnt_of(idx), model.size()); else nPass++;
            nChecks++; if (cnt_of(idx) > els) $display("[TB] FAIL rnd%0d_overfill got %0d exp <=%0d", idx, cnt_of(idx), els); else nPass++;
            nChecks++; if (outVal[idx] !== (model.size() != 0)) $display("[TB] FAIL rnd%0d_val got %b exp %b", idx, outVal[idx], model.size() != 0); else nPass++;
            nChecks++; if (inRdy[idx] !== (model.size() < els)) $display("[TB] FAIL rnd%0d_rdy got %b exp %b", idx, inRdy[idx], model.size() < els); else nPass++;
            nChecks++; if (outMsg[idx] !== expMsg) $display("[TB] FAIL rnd%0d_msg got %h exp %h", idx, outMsg[idx], expMsg); else nPass++;
            if (!pending) begin
                inVal[idx] = (sent < nMsgs) && ($urandom_range(3, 0) != 0);
                inMsg[idx] = brg_sys_make_msg(6'($urandom), 32'(sent));
            end
            outRdy[idx] = ($urandom_range(3, 0) != 0);
            enq = inVal[idx] && (model.size() < els);
            deq = outRdy[idx] && (model.size() != 0);
            if (deq) begin
                void'(model.pop_front());
                delivered++;
            end
            if (enq) begin
                model.push_back(inMsg[idx]);
                sent++;
            end
            pending = inVal[idx] && !enq;
        end
        nChecks++; if (delivered != nMsgs) $display("[TB] FAIL rnd%0d_timeout got %0d exp %0d", idx, delivered, nMsgs); else nPass++;
        @(negedge clk);
        inVal[idx] = 1'b0; outRdy[idx] = 1'b0;
        nChecks++; if (xfer[idx] !== 32'(nMsgs)) $display("[TB] FAIL rnd%0d_xfer got %0d exp %0d", idx, xfer[idx], nMsgs); else nPass++;
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        inVal[0] = 1'b1; inMsg[0] = 38'hA1; outRdy[0] = 1'b0;
        @(negedge clk);
        inMsg[0] = 38'hA2;
        @(negedge clk);
        inVal[0] = 1'b0;
        nChecks++; if (cnt_of(0) != 2) $display("[TB] FAIL mid_pre_count got %0d exp 2", cnt_of(0)); else nPass++;
        #1 resetN = 1'b0;
        #1;
        nChecks++; if (outVal[0] !== 1'b0) $display("[TB] FAIL mid_out_val got %b exp 0", outVal[0]); else nPass++;
        nChecks++; if (cnt_of(0) != 0) $display("[TB] FAIL mid_count got %0d exp 0", cnt_of(0)); else nPass++;
        nChecks++; if (xfer[0] !== 32'h0) $display("[TB] FAIL mid_xfer got %0d exp 0", xfer[0]); else nPass++;
        nChecks++; if (outMsg[0] !== 38'h0) $display("[TB] FAIL mid_out_msg got %h exp 0", outMsg[0]); else nPass++;
        #2 resetN = 1'b1;
        @(negedge clk);
        inVal[0] = 1'b1; inMsg[0] = 38'h55;
        @(negedge clk);
        inVal[0] = 1'b0;
        nChecks++; if (outMsg[0] !== 38'h55) $display("[TB] FAIL mid_new_msg got %h exp 55", outMsg[0]); else nPass++;
        nChecks++; if (cnt_of(0) != 1) $display("[TB] FAIL mid_new_count got %0d exp 1", cnt_of(0)); else nPass++;
        outRdy[0] = 1'b1;
        @(negedge clk);
        outRdy[0] = 1'b0;
        nChecks++; if (outVal[0] !== 1'b0) $display("[TB] FAIL mid_stale_val got %b exp 0", outVal[0]); else nPass++;
    endtask

    task automatic test_counter_wrap();
        logic [31:0] expX [4];
        expX[0] = 32'hFFFF_FFFE; expX[1] = 32'hFFFF_FFFF; expX[2] = 32'h0; expX[3] = 32'h1;
        @(negedge clk);
        dut0.r_xfer_count = 32'hFFFF_FFFE;
        inVal[0] = 1'b1; inMsg[0] = 38'h7; outRdy[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) inVal[0] = 1'b0;
            nChecks++; if (xfer[0] !== expX[i]) $display("[TB] FAIL wrap_xfer[%0d] got %h exp %h", i, xfer[0], expX[i]); else nPass++;
        end
        outRdy[0] = 1'b0;
    endtask

    initial begin
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inVal[i] = 1'b0; outRdy[i] = 1'b0; inMsg[i] = '0;
        end
        test_reset();
        test_single();
        test_fill_stall();
        test_streaming();
        test_random_backpressure(1, 3, 10000);
        test_random_backpressure(2, 5, 10000);
        test_reset_midstream();
        test_counter_wrap();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
